// File: rtl/aes_round_ctrl.sv
// Sequencing controller for an iterative AES-128 datapath.
// Drives key-expansion word indices, round indices and round-type strobes,
// and hands finished blocks to the consumer over a valid/ready handshake.
// No key or state data lives here; the datapath captures data on the strobes.
module aes_round_ctrl #(
   parameter int NR = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic       blk_valid,
   output logic       blk_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       key_load,
   output logic       kexp_en,
   output logic [5:0] kexp_idx,
   output logic       st_load,
   output logic       rnd_en,
   output logic [3:0] rnd_idx,
   output logic       rnd_final,
   output logic       key_ok,
   output logic       busy
);

   localparam int         KW      = 4 * (NR + 1);
   localparam logic [5:0] W_FIRST = 6'd4;
   localparam logic [5:0] W_LAST  = 6'(KW - 1);
   localparam logic [3:0] R_FIRST = 4'd1;
   localparam logic [3:0] R_LAST  = 4'(NR);

   typedef enum logic [2:0] {
      S_NOKEY,
      S_KEXP,
      S_KEYED,
      S_ROUND,
      S_DONE
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [5:0] r_widx,  w_widx_nxt;
   logic [3:0] r_ridx,  w_ridx_nxt;
   logic       w_key_acc;
   logic       w_blk_acc;

   // Handshake acceptance: a key always wins over a pending block in KEYED.
   always_comb begin
      w_key_acc = ((r_state == S_NOKEY) || (r_state == S_KEYED)) && key_valid;
      w_blk_acc = (r_state == S_KEYED) && !key_valid && blk_valid;
   end

   // State register and counters; synchronous reset aborts any operation.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge here, so it lives inside the
      // clocked branch rather than in the sensitivity list.
      if (rst) begin
         r_state <= S_NOKEY;
         r_widx  <= '0;
         r_ridx  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values of the previous cycle, independent of statement order.
         r_state <= w_state_nxt;
         r_widx  <= w_widx_nxt;
         r_ridx  <= w_ridx_nxt;
      end
   end

   // Next-state and counter update; counters are cleared when leaving KEXP/ROUND.
   always_comb begin
      // NOTE: hold values assigned first so no path leaves a variable
      // unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_widx_nxt  = r_widx;
      w_ridx_nxt  = r_ridx;
      unique case (r_state)
         S_NOKEY: begin
            if (w_key_acc) begin
               w_state_nxt = S_KEXP;
               w_widx_nxt  = W_FIRST;
            end
         end
         S_KEXP: begin
            if (r_widx == W_LAST) begin
               w_state_nxt = S_KEYED;
               w_widx_nxt  = '0;
            end else begin
               w_widx_nxt  = r_widx + 6'd1;
            end
         end
         S_KEYED: begin
            if (w_key_acc) begin
               w_state_nxt = S_KEXP;
               w_widx_nxt  = W_FIRST;
            end else if (w_blk_acc) begin
               w_state_nxt = S_ROUND;
               w_ridx_nxt  = R_FIRST;
            end
         end
         S_ROUND: begin
            if (r_ridx == R_LAST) begin
               w_state_nxt = S_DONE;
               w_ridx_nxt  = '0;
            end else begin
               w_ridx_nxt  = r_ridx + 4'd1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_KEYED;
            end
         end
         default: begin
            w_state_nxt = S_NOKEY;
            w_widx_nxt  = '0;
            w_ridx_nxt  = '0;
         end
      endcase
   end

   // Output decode; everything is forced low while reset is asserted.
   always_comb begin
      key_ready = 1'b0;
      blk_ready = 1'b0;
      out_valid = 1'b0;
      key_load  = 1'b0;
      kexp_en   = 1'b0;
      kexp_idx  = '0;
      st_load   = 1'b0;
      rnd_en    = 1'b0;
      rnd_idx   = '0;
      rnd_final = 1'b0;
      key_ok    = 1'b0;
      busy      = 1'b0;
      if (!rst) begin
         key_ready = (r_state == S_NOKEY) || (r_state == S_KEYED);
         blk_ready = (r_state == S_KEYED) && !key_valid;
         out_valid = (r_state == S_DONE);
         key_load  = w_key_acc;
         st_load   = w_blk_acc;
         kexp_en   = (r_state == S_KEXP);
         kexp_idx  = kexp_en ? r_widx : 6'd0;
         rnd_en    = (r_state == S_ROUND);
         rnd_idx   = rnd_en ? r_ridx : 4'd0;
         rnd_final = rnd_en && (r_ridx == R_LAST);
         key_ok    = (r_state == S_KEYED) || (r_state == S_ROUND) ||
                     (r_state == S_DONE);
         busy      = (r_state == S_KEXP) || (r_state == S_ROUND) ||
                     (r_state == S_DONE);
      end
   end

endmodule
